spinvaders_renderer: RTL
========================

SPINVADERS_RENDERER -- requirements
Module: spinvaders_renderer

Interface
REQ-001 Parameter PIX_DIV, default 4: Clk cycles per pixel; a pixel-enable pulse (pe) fires once every PIX_DIV cycles.
REQ-002 Parameter SHIP_Y, default 450: ship centre row.
REQ-003 Parameter SHIP_HW, default 15: ship half-width in pixels; ship half-height is fixed at 8.
REQ-004 Parameter ALIEN_HW, default 10: alien half-width and half-height in pixels.
REQ-005 Clk  input  1  system clock.
REQ-006 reset  input  1  reset, synchronous, active-high; clock Clk.
REQ-007 position  input  10  ship centre X.
REQ-008 projectileX, projectileY  input  10 each  projectile centre; projectileX==900 means no projectile.
REQ-009 topY, midY, botY  input  10 each  alien row centre Y.
REQ-010 alien1X..alien5X  input  10 each  top-row alien centre X.
REQ-011 alien6X..alien10X  input  10 each  mid-row alien centre X.
REQ-012 alien11X..alien15X  input  10 each  bottom-row alien centre X; any alien X >= 640 means destroyed/hidden.
REQ-013 hSync, vSync  output  1 each  VGA syncs, active-low.
REQ-014 vgaR, vgaG, vgaB  output  4 each  pixel colour.
REQ-015 frame_tick  output  1  one-Clk pulse at the start of vertical blank.

Function
REQ-016 Pixel counters SHALL be hCount 0..799 and vCount 0..524; both advance only on pe; hCount wraps 799->0 and increments vCount; vCount wraps 524->0.
REQ-017 Sync timing: hSync SHALL be low for hCount 656..751; vSync SHALL be low for vCount 490..491.
REQ-018 Visible region: hCount<640 and vCount<480; outside it RGB SHALL be 0.
REQ-019 Snapshot: on the pe where hCount==0 and vCount==480, all position inputs SHALL be latched into shadow registers; drawing uses only shadow values (no mid-frame tearing).
REQ-020 frame_tick SHALL assert for exactly one Clk cycle, on the same cycle as the REQ-019 latch.
REQ-021 Hit tests SHALL use 11-bit signed arithmetic so that centres below the half-width do not wrap.
REQ-022 Projectile SHALL be drawn when |x-projX|<=1 and |y-projY|<=5, unless projX==900.
REQ-023 Ship SHALL be drawn when |x-position|<=SHIP_HW and |y-SHIP_Y|<=8.
REQ-024 Alien k SHALL be drawn when alienX<640, |x-alienX|<=ALIEN_HW and |y-rowY|<=ALIEN_HW.
REQ-025 Colours: projectile FFF, ship 0F0, top-row alien F00, mid-row alien F0F, bottom-row alien 0FF, background 000.
REQ-026 Priority SHALL be projectile > ship > alien (top > mid > bot) > background.
REQ-027 Pipeline: RGB, hSync and vSync SHALL be registered and updated on pe, with an equal latency of 1 pixel from counter value to output.
REQ-028 Outputs SHALL hold between pe pulses.

Reset
REQ-029 On reset: pe divider=0, hCount=0, vCount=0, hSync=1, vSync=1, RGB=0, frame_tick=0.
REQ-030 On reset, shadow registers SHALL be loaded as: ship 400, projX 900, projY 0, rows 30/90/150, all aliens 950.
REQ-031 Reset asserted mid-frame SHALL take effect at the next Clk edge and override pe.

Verification
REQ-032 Reset release, run 4*800*525 cycles -> exactly one frame_tick; hSync low for 96 pixels per line; vSync low for 2 lines; periods 800 and 525.
REQ-033 position=400, no projectile, all aliens 950 -> pixel (385..415, 442..458) is 0F0; (384,450) and (416,450) are 000.
REQ-034 alien1X=30, topY=30 -> (20..40, 20..40) is F00; then set alien1X=950 mid-frame -> red persists until the next frame_tick, absent afterwards.
REQ-035 projectileX=400, projectileY=450, position=400 -> (400,450) is FFF (projectile over ship); (402,450) is 0F0.
REQ-036 position=5 -> ship spans x 0..20 with no wrap pixels near x=1000/1023; hCount 640..799 always outputs RGB 0.
REQ-037 Assert reset at vCount=200 -> next cycle counters are 0 and syncs are 1; after release, frame timing restarts from 0.

Source files
------------

// File: rtl/spinvaders_renderer.sv
// VGA 640x480 renderer for a Space-Invaders style playfield: sync generation,
// per-frame position snapshot and prioritised sprite colouring.
module spinvaders_renderer #(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned SHIP_Y   = 450,
  parameter int unsigned SHIP_HW  = 15,
  parameter int unsigned ALIEN_HW = 10
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [9:0] position,
  input  logic [9:0] projectileX,
  input  logic [9:0] projectileY,
  input  logic [9:0] topY,
  input  logic [9:0] midY,
  input  logic [9:0] botY,
  input  logic [9:0] alien1X,
  input  logic [9:0] alien2X,
  input  logic [9:0] alien3X,
  input  logic [9:0] alien4X,
  input  logic [9:0] alien5X,
  input  logic [9:0] alien6X,
  input  logic [9:0] alien7X,
  input  logic [9:0] alien8X,
  input  logic [9:0] alien9X,
  input  logic [9:0] alien10X,
  input  logic [9:0] alien11X,
  input  logic [9:0] alien12X,
  input  logic [9:0] alien13X,
  input  logic [9:0] alien14X,
  input  logic [9:0] alien15X,
  output logic       hSync,
  output logic       vSync,
  output logic [3:0] vgaR,
  output logic [3:0] vgaG,
  output logic [3:0] vgaB,
  output logic       frame_tick
);

  localparam int unsigned DivW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DivW-1:0] div_q;
  logic            pe;
  logic [9:0]      h_count_q, v_count_q;
  logic [9:0]      h_count_d, v_count_d;
  logic            snap;

  logic [9:0]      ship_q, proj_x_q, proj_y_q;
  logic [9:0]      row_y_q     [3];
  logic [9:0]      alien_x_q   [15];
  logic [9:0]      alien_x_in  [15];
  logic [9:0]      row_y_in    [3];

  logic            hsync_q, vsync_q, frame_tick_q;
  logic            hsync_d, vsync_d;
  logic [11:0]     rgb_q, rgb_d;
  logic [2:0]      row_hit;
  logic            proj_hit, ship_hit, visible;

  assign pe   = (div_q == DivW'(PIX_DIV - 1));
  assign snap = (h_count_q == 10'd0) && (v_count_q == 10'd480);

  // Signed 11-bit distance so centres near 0 do not wrap around.
  function automatic logic near(input logic [9:0] a, input logic [9:0] c, input int unsigned hw);
    logic signed [10:0] d;
    logic [10:0]        mag;
    d   = $signed({1'b0, a}) - $signed({1'b0, c});
    mag = d[10] ? 11'(-d) : 11'(d);
    return mag <= 11'(hw);
  endfunction

  always_comb begin
    alien_x_in = '{alien1X, alien2X, alien3X, alien4X, alien5X,
                   alien6X, alien7X, alien8X, alien9X, alien10X,
                   alien11X, alien12X, alien13X, alien14X, alien15X};
    row_y_in   = '{topY, midY, botY};
  end

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (h_count_q == 10'd799) begin
      h_count_d = 10'd0;
      v_count_d = (v_count_q == 10'd524) ? 10'd0 : v_count_q + 10'd1;
    end else begin
      h_count_d = h_count_q + 10'd1;
    end
  end

  always_comb begin
    row_hit = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        if (alien_x_q[r*5+k] < 10'd640 && near(h_count_q, alien_x_q[r*5+k], ALIEN_HW) &&
            near(v_count_q, row_y_q[r], ALIEN_HW)) begin
          row_hit[r] = 1'b1;
        end
      end
    end
    proj_hit = (proj_x_q != 10'd900) && near(h_count_q, proj_x_q, 1) &&
               near(v_count_q, proj_y_q, 5);
    ship_hit = near(h_count_q, ship_q, SHIP_HW) && near(v_count_q, 10'(SHIP_Y), 8);
    visible  = (h_count_q < 10'd640) && (v_count_q < 10'd480);

    rgb_d = 12'h000;
    if (visible) begin
      if (proj_hit)        rgb_d = 12'hFFF;
      else if (ship_hit)   rgb_d = 12'h0F0;
      else if (row_hit[0]) rgb_d = 12'hF00;
      else if (row_hit[1]) rgb_d = 12'hF0F;
      else if (row_hit[2]) rgb_d = 12'h0FF;
    end
    hsync_d = !((h_count_q >= 10'd656) && (h_count_q <= 10'd751));
    vsync_d = !((v_count_q >= 10'd490) && (v_count_q <= 10'd491));
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      div_q        <= '0;
      h_count_q    <= '0;
      v_count_q    <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      rgb_q        <= '0;
      frame_tick_q <= 1'b0;
      ship_q       <= 10'd400;
      proj_x_q     <= 10'd900;
      proj_y_q     <= 10'd0;
      row_y_q      <= '{10'd30, 10'd90, 10'd150};
      for (int i = 0; i < 15; i++) alien_x_q[i] <= 10'd950;
    end else begin
      div_q        <= pe ? '0 : div_q + DivW'(1);
      frame_tick_q <= pe && snap;
      if (pe) begin
        h_count_q <= h_count_d;
        v_count_q <= v_count_d;
        hsync_q   <= hsync_d;
        vsync_q   <= vsync_d;
        rgb_q     <= rgb_d;
        if (snap) begin
          ship_q   <= position;
          proj_x_q <= projectileX;
          proj_y_q <= projectileY;
          row_y_q  <= row_y_in;
          for (int i = 0; i < 15; i++) alien_x_q[i] <= alien_x_in[i];
        end
      end
    end
  end

  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign vgaR       = rgb_q[11:8];
  assign vgaG       = rgb_q[7:4];
  assign vgaB       = rgb_q[3:0];
  assign frame_tick = frame_tick_q;

endmodule
